// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: DEPTH-entry in-order circular buffer carrying
// {pc, instr, exception_type} with valid/ready handshakes and an exception flush.
module if_id_queue #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned EXC_W  = 6,
  parameter int unsigned DEPTH  = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_instr,
  input  logic [EXC_W-1:0]  if_exception_type,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_instr,
  output logic [EXC_W-1:0]  id_exception_type,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] pc_mem_q    [DEPTH];
  logic [INST_W-1:0] instr_mem_q [DEPTH];
  logic [EXC_W-1:0]  exc_mem_q   [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic full, empty, push, pop;

  // Handshake terms depend on registered occupancy only.
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign push  = if_valid && !full;
  assign pop   = id_ready && !empty;

  assign if_ready = !full;
  assign id_valid = !empty;
  assign count    = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= if_pc;
      instr_mem_q[wr_ptr_q] <= if_instr;
      exc_mem_q[wr_ptr_q]   <= if_exception_type;
    end
  end

  always_comb begin
    id_pc             = '0;
    id_instr          = '0;
    id_exception_type = '0;
    if (!empty) begin
      id_pc             = pc_mem_q[rd_ptr_q];
      id_instr          = instr_mem_q[rd_ptr_q];
      id_exception_type = exc_mem_q[rd_ptr_q];
    end
  end

endmodule
